block_transfer_unit: RTL and testbench
======================================

# block_transfer_unit

Multi-cycle sequencer for Thumb PUSH/POP (and optionally LDMIA/STMIA) that acts as the initiator on the register file's read/write ports and on the data-memory port. It sits between the decoder and the register file. On a single start pulse it walks a register list one register per memory transaction, then writes back the updated base register, stalling the core via `busy` until done.

## Interface
- `ADDR_W`, 32: memory address and data width
- `clk`  in  1: core clock, rising edge
- `rst_n`  in  1: asynchronous active-low reset
- `start`  in  1: one-cycle request; sampled only in IDLE
- `op`  in  2: 00 PUSH, 01 POP, 10 STMIA, 11 LDMIA (10/11 need `BTU_LDM_STM_EN`)
- `reg_list`  in  8: R0..R7 mask
- `r_bit`  in  1: PUSH adds LR, POP adds PC
- `base_sel`  in  3: Rn for LDMIA/STMIA; ignored for PUSH/POP
- `regA_select`  out  4: register file port A select (base register)
- `regB_select`  out  4: register file port B select (store data)
- `regA_data`, `regB_data`  in  32: register file read data
- `write_dest`  out  4: register file write select
- `write_en`  out  1: register file write strobe
- `write_data`  out  32: register file write data
- `mem_req`, `mem_we`  out  1: memory request / write
- `mem_addr`, `mem_wdata`  out  32: word address, store data
- `mem_rdata`  in  32: load data, valid with `mem_ready`
- `mem_ready`  in  1: transaction accepted/completed this cycle
- `busy`  out  1: high from the cycle after `start` until DONE; `done`  out  1: one-cycle pulse

## Operation
- Encodings: R0–R7 4'h0–4'h7, SP 4'h8, PC 4'h9, LR 4'hA.
- States: IDLE, CALC, XFER, WBASE, DONE.
- IDLE: all strobes low. `start` latches op, list, r_bit, base -> CALC.
- CALC (1 cycle): `regA_select` = base (SP for PUSH/POP). `n` = popcount(list)+r_bit (0..9); offset = n<<2. PUSH: addr = base−offset, new_base = addr. POP/LDMIA/STMIA: addr = base, new_base = base+offset. Mod 2^32 wrap. n=0 -> DONE directly, no memory or register writes.
- XFER: lowest-numbered pending register first; LR/PC last. Stores: `regB_select` = reg, `mem_wdata` = `regB_data`, `mem_we`=1. Loads: `mem_we`=0; on `mem_ready`, `write_en`=1, `write_dest` = reg, `write_data` = `mem_rdata`. `mem_req`, `mem_addr`, `mem_we` held stable until `mem_ready`; then clear register from pending mask, addr += 4. Empty mask -> WBASE.
- WBASE (1 cycle): `write_en`=1, `write_dest` = base, `write_data` = new_base. LDMIA skips writeback when Rn is in the list (loaded value wins).
- DONE: `done`=1 one cycle -> IDLE.
- `start` while not IDLE: ignored.
- Async reset: state IDLE, all outputs 0; registers already written remain written.

## Timing
- Reset values: all outputs 0 (`regA_select`, `regB_select`, `write_dest` = 4'h0).
- Latency: start -> done = 3 + Σ(cycles per transfer) cycles; zero-wait memory gives 3+n (n≥1), 2 for n=0.
- Load register write occurs in the same cycle as `mem_ready`; never two writes per cycle.
- `mem_ready` outside XFER ignored.

## Configuration
- `BTU_LDM_STM_EN` defined: op 10/11 supported, base = R`base_sel`, r_bit ignored for them.
- Undefined: op[1] ignored (10 behaves as PUSH, 11 as POP); `base_sel` unused; base always SP.

## Structure
- Shared header/package: register encodings (R0–R7, SP, PC, LR, IMM), op codes, state encoding; same constants used by the register file and decoder.
- One sub-module: `lowest_set_picker` (9-bit mask -> one-hot grant + 4-bit register code, LR/PC mapped per op).

## Test plan
- PUSH {R1,R4,LR}, SP=0x1000, zero-wait -> stores R1@0xFF4, R4@0xFF8, LR@0xFFC; SP=0xFF4; done 6 cycles after start.
- POP {R0,PC}, SP=0xFF8, mem 0xFF8=0x11, 0xFFC=0x200 -> R0=0x11, PC=0x200, SP=0x1000.
- POP {R2} with `mem_ready` delayed 3 cycles -> `mem_req`/`mem_addr` stable 3 cycles, single write R2, one extra write SP.
- Empty list, r_bit=0 -> no `mem_req`, no `write_en`, done 2 cycles after start.
- PUSH {R0}, SP=0x2 -> addr 0xFFFFFFFE, SP wraps to 0xFFFFFFFE; `rst_n` low mid-XFER -> outputs 0 immediately, IDLE, new start accepted.
- With `BTU_LDM_STM_EN`: LDMIA R3!,{R1,R3}, R3=0x40 -> R1, R3 loaded, no base writeback.

Source files
------------

// File: rtl/block_transfer_unit_pkg.sv
// Shared constants for the block transfer unit, register file and decoder.
//   - register file encodings (R0..R7, SP, PC, LR, IMM)
//   - block transfer op codes
//   - sequencer state encoding
//   - popcount helper for the 9-bit transfer mask
package block_transfer_unit_pkg;

  localparam logic [3:0] REG_R0  = 4'h0;
  localparam logic [3:0] REG_R7  = 4'h7;
  localparam logic [3:0] REG_SP  = 4'h8;
  localparam logic [3:0] REG_PC  = 4'h9;
  localparam logic [3:0] REG_LR  = 4'hA;
  localparam logic [3:0] REG_IMM = 4'hF;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_STMIA = 2'b10;
  localparam logic [1:0] OP_LDMIA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_XFER  = 3'd2,
    ST_WBASE = 3'd3,
    ST_DONE  = 3'd4
  } btu_state_t;

  // Number of registers in a transfer mask (bit 8 = LR/PC slot).
  function automatic logic [3:0] popcount9(input logic [8:0] m);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 9; i++) begin
      cnt = cnt + {3'd0, m[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/block_transfer_unit_picker.sv
// lowest_set_picker: selects the lowest pending entry of a 9-bit transfer mask.
//   mask    in  9 : bits 0..7 = R0..R7, bit 8 = LR (stores) / PC (loads)
//   is_load in  1 : maps bit 8 to PC when set, LR otherwise
//   grant   out 9 : one-hot of the selected entry (0 when mask is empty)
//   code    out 4 : register file encoding of the selected entry
module lowest_set_picker
  import block_transfer_unit_pkg::*;
(
  input  logic [8:0] mask,
  input  logic       is_load,
  output logic [8:0] grant,
  output logic [3:0] code
);

  always_comb begin
    // Isolate the lowest set bit; bit 8 is therefore always serviced last.
    grant = mask & (~mask + 9'd1);
    code  = REG_R0;
    for (int i = 0; i < 8; i++) begin
      if (grant[i]) begin
        code = 4'(i);
      end
    end
    if (grant[8]) begin
      code = is_load ? REG_PC : REG_LR;
    end
  end

endmodule

// File: rtl/block_transfer_unit.sv
// block_transfer_unit: multi-cycle PUSH/POP (optionally LDMIA/STMIA) sequencer.
// Walks a register list one memory transaction per register, then writes back
// the updated base register. Optional feature macro: BTU_LDM_STM_EN enables
// op 10/11 (STMIA/LDMIA with base R<base_sel>); without it op[1] is ignored and
// the base is always SP.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, op, reg_list,
//   r_bit, base_sel        : request from the decoder (sampled in IDLE only)
//   regA_select/regA_data  : base register read port
//   regB_select/regB_data  : store data read port
//   write_dest/en/data     : register file write port
//   mem_req/we/addr/wdata,
//   mem_rdata/mem_ready    : data memory port
//   busy, done             : core stall and completion pulse
module block_transfer_unit
  import block_transfer_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [7:0]        reg_list,
  input  logic              r_bit,
  input  logic [2:0]        base_sel,
  output logic [3:0]        regA_select,
  output logic [3:0]        regB_select,
  input  logic [ADDR_W-1:0] regA_data,
  input  logic [ADDR_W-1:0] regB_data,
  output logic [3:0]        write_dest,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  btu_state_t        state_q, state_d;
  logic [8:0]        pend_q;
  logic [1:0]        op_q;
  logic [3:0]        base_q;
  logic              skip_wb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] new_base_q;

  logic [1:0]        op_eff;
  logic [3:0]        base_eff;
  logic              rbit_eff;
  logic              skip_eff;

  logic              is_load;
  logic              is_push;
  logic [3:0]        n_xfer;
  logic [ADDR_W-1:0] offset;
  logic [8:0]        grant;
  logic [3:0]        code;
  logic              last_xfer;

  // Request decode at start time.
  always_comb begin
`ifdef BTU_LDM_STM_EN
    op_eff   = op;
    base_eff = op[1] ? {1'b0, base_sel} : REG_SP;
    rbit_eff = op[1] ? 1'b0 : r_bit;
    // LDMIA with Rn in the list: the loaded value must survive.
    skip_eff = (op == OP_LDMIA) && reg_list[base_sel];
`else
    op_eff   = {1'b0, op[0]};
    base_eff = REG_SP;
    rbit_eff = r_bit;
    skip_eff = 1'b0;
`endif
  end

`ifndef BTU_LDM_STM_EN
  logic unused_base_sel;
  assign unused_base_sel = ^base_sel;
`endif

  assign is_load   = op_q[0];
  assign is_push   = (op_q == OP_PUSH);
  assign n_xfer    = popcount9(pend_q);
  assign offset    = ADDR_W'(n_xfer) << 2;
  assign last_xfer = ((pend_q & ~grant) == 9'd0);

  lowest_set_picker u_picker (
    .mask    (pend_q),
    .is_load (is_load),
    .grant   (grant),
    .code    (code)
  );

  // Control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        pend_q <= {rbit_eff, reg_list};
      end else if (state_q == ST_XFER && mem_ready) begin
        pend_q <= pend_q & ~grant;
      end
    end
  end

  // Datapath holding registers; their contents only matter outside IDLE.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      op_q      <= op_eff;
      base_q    <= base_eff;
      skip_wb_q <= skip_eff;
    end
    if (state_q == ST_CALC) begin
      // PUSH stores downward from base-offset; everything else walks up from base.
      addr_q     <= is_push ? (regA_data - offset) : regA_data;
      new_base_q <= is_push ? (regA_data - offset) : (regA_data + offset);
    end else if (state_q == ST_XFER && mem_ready) begin
      addr_q <= addr_q + ADDR_W'(4);
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CALC;
      ST_CALC:  state_d = (n_xfer == 4'd0) ? ST_DONE : ST_XFER;
      ST_XFER:  if (mem_ready && last_xfer) state_d = ST_WBASE;
      ST_WBASE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so that reset clears them immediately.
  always_comb begin
    regA_select = REG_R0;
    regB_select = REG_R0;
    write_dest  = REG_R0;
    write_en    = 1'b0;
    write_data  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_CALC: begin
        busy        = 1'b1;
        regA_select = base_q;
      end
      ST_XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr_q;
        mem_we   = ~is_load;
        if (!is_load) begin
          regB_select = code;
          mem_wdata   = regB_data;
        end else if (mem_ready) begin
          write_en   = 1'b1;
          write_dest = code;
          write_data = mem_rdata;
        end
      end
      ST_WBASE: begin
        busy = 1'b1;
        if (!skip_wb_q) begin
          write_en   = 1'b1;
          write_dest = base_q;
          write_data = new_base_q;
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_block_transfer_unit.sv
module tb_block_transfer_unit;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } wr_txn_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  reg_list;
  logic        r_bit;
  logic [2:0]  base_sel;
  logic [3:0]  regA_select, regB_select, write_dest;
  logic [31:0] regA_data, regB_data, write_data;
  logic        write_en, mem_req, mem_we, mem_ready, busy, done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];

  mem_txn_t exp_mem[$];
  wr_txn_t  exp_wr[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cycles = 0;
  int stall_cycles = 0;
  int wait_fixed = 0;
  int wait_max = 0;
  int wait_left = 0;
  bit prev_req = 0;
  bit hold_pending = 0;
  logic [31:0] hold_addr;
  logic hold_we;

  block_transfer_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .reg_list    (reg_list),
    .r_bit       (r_bit),
    .base_sel    (base_sel),
    .regA_select (regA_select),
    .regB_select (regB_select),
    .regA_data   (regA_data),
    .regB_data   (regB_data),
    .write_dest  (write_dest),
    .write_en    (write_en),
    .write_data  (write_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .done        (done)
  );

  assign regA_data = rf[regA_select];
  assign regB_data = rf[regB_select];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: programmable wait states, random mem_ready when idle.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ready = 1'b0;
      prev_req  = 1'b0;
    end else if (mem_req) begin
      if (!prev_req || mem_ready)
        wait_left = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, wait_max));
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_rdata = rd(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wait_left--;
      end
      prev_req = 1'b1;
    end else begin
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      prev_req  = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  always @(negedge clk) begin
    mem_txn_t em;
    wr_txn_t  ew;
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      if (mem_req) begin
        req_cycles++;
        if (!mem_ready) stall_cycles++;
      end
      if (hold_pending)
        chk("mem_hold", {mem_req, mem_we, mem_addr[29:0]}, {1'b1, hold_we, hold_addr[29:0]});
      hold_pending = mem_req && !mem_ready;
      hold_addr = mem_addr;
      hold_we = mem_we;
      if (mem_req && mem_ready) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem: addr %h we %b", mem_addr, mem_we);
        end else begin
          em = exp_mem.pop_front();
          chk("mem_we", 32'(mem_we), 32'(em.we));
          chk("mem_addr", mem_addr, em.addr);
          if (em.we) chk("mem_wdata", mem_wdata, em.data);
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
      if (write_en) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: dest %h data %h", write_dest, write_data);
        end else begin
          ew = exp_wr.pop_front();
          chk("write_dest", 32'(write_dest), 32'(ew.dest));
          chk("write_data", write_data, ew.data);
        end
        rf[write_dest] = write_data;
      end
    end
  end

  // Reference model + driver for one block transfer.
  task automatic run_op(input logic [1:0] op_i, input logic [7:0] lst, input logic rb,
                        input logic [2:0] bsel, input int abort_at, output int lat);
    logic [1:0]  eop;
    logic        is_ld, is_push, rbe, skip;
    logic [3:0]  base;
    int          regs[$];
    int          n, s;
    logic [31:0] bv, a0, nb, fb, a;
    bit          seen;
`ifdef BTU_LDM_STM_EN
    eop = op_i;
`else
    eop = {1'b0, op_i[0]};
`endif
    is_ld   = eop[0];
    is_push = (eop == 2'b00);
    base    = eop[1] ? {1'b0, bsel} : 4'h8;
    rbe     = eop[1] ? 1'b0 : rb;
    for (int i = 0; i < 8; i++) if (lst[i]) regs.push_back(i);
    if (rbe) regs.push_back(is_ld ? 9 : 10);
    n    = regs.size();
    bv   = rf[base];
    a0   = is_push ? bv - 32'(n * 4) : bv;
    nb   = is_push ? a0 : bv + 32'(n * 4);
    skip = (eop == 2'b11) && lst[bsel];
    fb   = (n == 0) ? bv : nb;
    for (int k = 0; k < n; k++) begin
      a = a0 + 32'(4 * k);
      if (is_ld) begin
        exp_mem.push_back({1'b0, a, 32'h0});
        exp_wr.push_back({4'(regs[k]), rd(a)});
        if (skip && regs[k] == int'(base)) fb = rd(a);
      end else begin
        exp_mem.push_back({1'b1, a, rf[regs[k]]});
      end
    end
    if (n > 0 && !skip) exp_wr.push_back({base, nb});

    @(negedge clk);
    op = op_i; reg_list = lst; r_bit = rb; base_sel = bsel; start = 1'b1;
    s = cyc; req_cycles = 0; stall_cycles = 0;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); reg_list = 8'($urandom); r_bit = 1'($urandom); base_sel = 3'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = -1;
    seen = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      start = (t == 0);
      if (abort_at > 0 && t == abort_at) begin
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 32'({busy, done, mem_req, mem_we, write_en, regA_select, regB_select, write_dest}), 32'd0);
        chk("abort_data", mem_addr | mem_wdata | write_data, 32'd0);
        exp_mem.delete();
        exp_wr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        return;
      end
      if (done) begin
        seen = 1;
        lat = cyc - s;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: op %b list %h", op_i, lst);
      exp_mem.delete();
      exp_wr.delete();
      return;
    end
    chk("latency", 32'(lat), 32'((n == 0) ? 2 : 3 + n + stall_cycles));
    chk("final_base", rf[base], fb);
    chk("queues_empty", 32'(exp_mem.size() + exp_wr.size()), 32'd0);
    if (n == 0) chk("no_mem_req", 32'(req_cycles), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; reg_list = 8'h00; r_bit = 1'b0; base_sel = 3'd0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 * 32'(i) + 32'h1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 32'({busy, done, mem_req, mem_we, write_en, regA_select, regB_select, write_dest}), 32'd0);
    chk("reset_data", mem_addr | mem_wdata | write_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // PUSH {R1,R4,LR}, SP=0x1000, zero wait.
    wait_fixed = 0;
    rf[8] = 32'h1000; rf[1] = 32'hAAAA_0001; rf[4] = 32'hAAAA_0004; rf[10] = 32'hAAAA_000A;
    run_op(2'b00, 8'b0001_0010, 1'b1, 3'd0, 0, lat);
    chk("push_latency", 32'(lat), 32'd6);
    chk("push_sp", rf[8], 32'h0000_0FF4);
    chk("push_lr_mem", rd(32'hFFC), 32'hAAAA_000A);

    // POP {R0,PC}, SP=0xFF8.
    rf[8] = 32'hFF8; mem[32'hFF8] = 32'h11; mem[32'hFFC] = 32'h200;
    run_op(2'b01, 8'b0000_0001, 1'b1, 3'd0, 0, lat);
    chk("pop_r0", rf[0], 32'h11);
    chk("pop_pc", rf[9], 32'h200);
    chk("pop_sp", rf[8], 32'h1000);

    // POP {R2} with three wait states.
    wait_fixed = 3;
    run_op(2'b01, 8'b0000_0100, 1'b0, 3'd0, 0, lat);
    chk("pop_wait_stalls", 32'(stall_cycles), 32'd3);
    chk("pop_wait_latency", 32'(lat), 32'd7);
    wait_fixed = 0;

    // Empty list.
    run_op(2'b00, 8'h00, 1'b0, 3'd0, 0, lat);
    chk("empty_latency", 32'(lat), 32'd2);

    // PUSH {R0} with SP wrap.
    rf[8] = 32'h2; rf[0] = 32'h5555_0000;
    run_op(2'b00, 8'b0000_0001, 1'b0, 3'd0, 0, lat);
    chk("wrap_sp", rf[8], 32'hFFFF_FFFE);
    chk("wrap_mem", rd(32'hFFFF_FFFE), 32'h5555_0000);

    // Reset in the middle of a PUSH, then a fresh request.
    rf[8] = 32'h3000;
    run_op(2'b00, 8'h3F, 1'b1, 3'd0, 3, lat);
    run_op(2'b01, 8'h0C, 1'b0, 3'd0, 0, lat);

`ifdef BTU_LDM_STM_EN
    // LDMIA R3!, {R1,R3}: base loaded, no writeback.
    rf[3] = 32'h40; mem[32'h40] = 32'hAAA; mem[32'h44] = 32'hBBB;
    run_op(2'b11, 8'b0000_1010, 1'b0, 3'd3, 0, lat);
    chk("ldm_r1", rf[1], 32'hAAA);
    chk("ldm_r3", rf[3], 32'hBBB);
`endif

    // Randomised operations with random wait states.
    rf[8] = 32'h0000_8000;
    wait_fixed = -1;
    wait_max = 2;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] l;
      logic rb;
      l = 8'($urandom);
      rb = 1'($urandom);
      if ((i % 9) == 4) begin
        l = 8'h00;
        rb = 1'b0;
      end
      run_op(2'($urandom), l, rb, 3'($urandom), 0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
